// File: rtl/stream_output_arbiter_pkg.sv
// Shared types and constants for the stream output arbiter.
package stream_output_arbiter_pkg;

  localparam int unsigned STATE_W     = 2;
  localparam int unsigned BURST_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ARB     = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2
  } state_t;

endpackage

// File: rtl/stream_output_arbiter_rr_priority_pick.sv
// Round-robin pick: first requester strictly after last_grant, with wrap.
module rr_priority_pick #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  last_grant,
  output logic [SEL_W-1:0]  pick,
  output logic              valid
);

  int unsigned pos;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    pos   = 0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      pos = (32'(last_grant) + k) % NUM_IN;
      if (!valid && req[SEL_W'(pos)]) begin
        pick  = SEL_W'(pos);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_output_arbiter.sv
// Round-robin, burst-limited arbiter sharing one stb/ack output among NUM_IN producers.
module stream_output_arbiter
  import stream_output_arbiter_pkg::*;
#(
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned SEL_W     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_stb,
  output logic [NUM_IN-1:0]       in_ack,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_stb,
  input  logic                    out_ack,
  output logic [SEL_W-1:0]        out_source,
  output logic                    busy,
  output logic                    exception
);

  localparam int unsigned CNT_CMP_W = BURST_CNT_W + 1;

  state_t                 state, state_nxt;
  logic [SEL_W-1:0]       grant, grant_nxt;
  logic [SEL_W-1:0]       last_grant, last_grant_nxt;
  logic [BURST_CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic [WIDTH-1:0]       out_data_nxt;
  logic [SEL_W-1:0]       out_source_nxt;
  logic                   exception_nxt;
  logic [NUM_IN-1:0]      in_ack_nxt;
  logic [WIDTH-1:0]       words [NUM_IN];
  logic [SEL_W-1:0]       pick;
  logic                   pick_valid;
  logic                   burst_more;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
    assign words[i] = in_data[i*WIDTH +: WIDTH];
  end

  rr_priority_pick #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_pick (
    .req        (in_stb),
    .last_grant (last_grant),
    .pick       (pick),
    .valid      (pick_valid)
  );

  // Current grant may keep the channel for another word.
  assign burst_more = (({1'b0, burst_cnt} + CNT_CMP_W'(1)) < CNT_CMP_W'(MAX_BURST))
                      && in_stb[grant];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (pick_valid) state_nxt = CAPTURE;
      CAPTURE: state_nxt = in_stb[grant] ? SEND : ARB;
      SEND:    if (out_ack) state_nxt = burst_more ? CAPTURE : ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = burst_cnt;
    out_data_nxt   = out_data;
    out_source_nxt = out_source;
    exception_nxt  = exception;
    in_ack_nxt     = '0;
    case (state)
      ARB: begin
        if (pick_valid) begin
          grant_nxt     = pick;
          burst_cnt_nxt = '0;
        end
      end
      CAPTURE: begin
        if (in_stb[grant]) begin
          out_data_nxt   = words[grant];
          out_source_nxt = grant;
        end else begin
          // Producer withdrew its word before the handshake: flag and drop it.
          exception_nxt  = 1'b1;
          last_grant_nxt = grant;
        end
      end
      SEND: begin
        if (out_ack) begin
          burst_cnt_nxt = burst_cnt + BURST_CNT_W'(1);
          if (!burst_more) last_grant_nxt = grant;
        end
      end
      default: ;
    endcase
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      in_ack_nxt[i] = (state_nxt == CAPTURE) && (grant_nxt == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant      <= '0;
      last_grant <= SEL_W'(NUM_IN - 1);
      burst_cnt  <= '0;
      out_data   <= '0;
      out_source <= '0;
      out_stb    <= 1'b0;
      in_ack     <= '0;
      busy       <= 1'b0;
      exception  <= 1'b0;
    end else begin
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
      out_data   <= out_data_nxt;
      out_source <= out_source_nxt;
      out_stb    <= (state_nxt == SEND);
      in_ack     <= in_ack_nxt;
      busy       <= (state_nxt != ARB);
      exception  <= exception_nxt;
    end
  end

endmodule
